// File: rtl/svc_rv_io_pkg.sv
// Shared types and constants for the RV core MMIO demultiplexer.
package svc_rv_io_pkg;

    // Width of the saturating unmapped-access counter.
    localparam int ERR_CNT_W = 16;

    // Target index width; covers the maximum of 8 targets.
    localparam int IDX_W = 3;

    // One stage of the read-tag pipeline that travels alongside a read.
    typedef struct packed {
        logic             valid;
        logic             mapped;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/svc_rv_io_decode.sv
// Combinational address decode: finds the lowest-index region containing
// the address and returns a one-hot select, index and in-region offset.
module svc_rv_io_decode
    import svc_rv_io_pkg::*;
#(
    parameter int                     NUM_TGT = 4,
    parameter int                     AW      = 32,
    parameter int                     TGT_AW  = 10,
    parameter logic [NUM_TGT*AW-1:0]  BASES   = '0
) (
    input  logic [AW-1:0]      addr_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_TGT-1:0] sel_o,
    output logic [AW-1:0]      offset_o
);

    logic [NUM_TGT-1:0] match;

    // Per-target region compare on the bits above the region size.
    generate
        for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_match
            localparam logic [AW-1:0] BASE = BASES[gi*AW +: AW];
            assign match[gi] = (addr_i[AW-1:TGT_AW+2] == BASE[AW-1:TGT_AW+2]);
        end
    endgenerate

    // Priority pick: scan high to low so the lowest matching index wins.
    always_comb begin
        hit_o    = 1'b0;
        idx_o    = '0;
        sel_o    = '0;
        offset_o = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o    = 1'b1;
                idx_o    = IDX_W'(i);
                sel_o    = '0;
                sel_o[i] = 1'b1;
                offset_o = addr_i - BASES[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/svc_rv_io_demux.sv
// MMIO demultiplexer between the core io_* port and NUM_TGT targets, with
// an in-order read-return tag pipeline and sticky unmapped-access logging.
module svc_rv_io_demux
    import svc_rv_io_pkg::*;
#(
    parameter int                    NUM_TGT        = 4,
    parameter int                    AW             = 32,
    parameter int                    DW             = 32,
    parameter int                    TGT_AW         = 10,
    parameter logic [NUM_TGT*AW-1:0] BASES          = {32'h0000_3000, 32'h0000_2000,
                                                       32'h0000_1000, 32'h0000_0000},
    parameter int                    RD_LAT         = 1,
    parameter int                    OUT_REG        = 0,
    parameter logic [DW-1:0]         UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_ren,
    input  logic [AW-1:0]         io_raddr,
    output logic [DW-1:0]         io_rdata,
    input  logic                  io_wen,
    input  logic [AW-1:0]         io_waddr,
    input  logic [DW-1:0]         io_wdata,
    input  logic [DW/8-1:0]       io_wstrb,
    output logic [NUM_TGT-1:0]    tgt_ren,
    output logic [AW-1:0]         tgt_raddr,
    input  logic [NUM_TGT*DW-1:0] tgt_rdata,
    output logic [NUM_TGT-1:0]    tgt_wen,
    output logic [AW-1:0]         tgt_waddr,
    output logic [DW-1:0]         tgt_wdata,
    output logic [DW/8-1:0]       tgt_wstrb,
    input  logic                  err_clr,
    output logic                  err,
    output logic [AW-1:0]         err_addr,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    logic               hit_r, hit_w;
    logic [IDX_W-1:0]   idx_r, idx_w;
    logic [NUM_TGT-1:0] sel_r, sel_w;
    logic [AW-1:0]      off_r, off_w;

    svc_rv_io_decode #(
        .NUM_TGT (NUM_TGT),
        .AW      (AW),
        .TGT_AW  (TGT_AW),
        .BASES   (BASES)
    ) u_dec_r (
        .addr_i   (io_raddr),
        .hit_o    (hit_r),
        .idx_o    (idx_r),
        .sel_o    (sel_r),
        .offset_o (off_r)
    );

    svc_rv_io_decode #(
        .NUM_TGT (NUM_TGT),
        .AW      (AW),
        .TGT_AW  (TGT_AW),
        .BASES   (BASES)
    ) u_dec_w (
        .addr_i   (io_waddr),
        .hit_o    (hit_w),
        .idx_o    (idx_w),
        .sel_o    (sel_w),
        .offset_o (off_w)
    );

    logic wr_active;
    assign wr_active = io_wen & (|io_wstrb);

    // Strobes are held off during reset so no target sees a half-reset access.
    assign tgt_ren   = (io_ren & ~rst)    ? sel_r : '0;
    assign tgt_wen   = (wr_active & ~rst) ? sel_w : '0;
    assign tgt_raddr = off_r;
    assign tgt_waddr = off_w;
    assign tgt_wdata = io_wdata;
    assign tgt_wstrb = io_wstrb;

    // ---------------- read-tag pipeline ----------------
    rd_tag_t tag_q [RD_LAT];
    rd_tag_t tag0_d;
    rd_tag_t tag_last;

    // Stage-0 tag describes whatever read is issued this cycle.
    always_comb begin
        tag0_d        = '0;
        tag0_d.valid  = io_ren;
        tag0_d.mapped = hit_r;
        tag0_d.idx    = idx_r;
    end

    // Shift tags in lockstep with the target read latency; reset flushes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag0_d;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_last = tag_q[RD_LAT-1];

    logic [DW-1:0] rdata_d;

    // Steer the returning target data selected by the oldest tag.
    always_comb begin
        rdata_d = '0;
        if (tag_last.valid) begin
            if (tag_last.mapped) rdata_d = tgt_rdata[int'(tag_last.idx)*DW +: DW];
            else                 rdata_d = UNMAPPED_RDATA;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] rdata_q;
            // Optional output register for timing closure on the return path.
            always_ff @(posedge clk) begin
                if (rst) rdata_q <= '0;
                else     rdata_q <= rdata_d;
            end
            assign io_rdata = rdata_q;
        end else begin : g_out_comb
            assign io_rdata = rdata_d;
        end
    endgenerate

    // ---------------- error logging ----------------
    logic                 err_q, err_d;
    logic [AW-1:0]        err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 rd_err, wr_err;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   cnt_sum;

    assign rd_err  = io_ren & ~hit_r;
    assign wr_err  = wr_active & ~hit_w;
    assign err_inc = {1'b0, rd_err} + {1'b0, wr_err};
    assign cnt_sum = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(err_inc);

    // Next error state: clear beats events; the first address sticks until cleared.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (rd_err | wr_err) begin
            err_d     = 1'b1;
            err_cnt_d = cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
            if (!err_q) err_addr_d = rd_err ? io_raddr : io_waddr;
        end
    end

    // Error state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_svc_rv_io_demux.sv
// Directed bench: three demux instances (RD_LAT 1, 2, 3) share the same stimulus.
module tb_svc_rv_io_demux;

    logic         clk = 1'b0;
    logic         rst;
    logic         io_ren, io_wen, err_clr;
    logic [31:0]  io_raddr, io_waddr, io_wdata;
    logic [3:0]   io_wstrb;
    logic [127:0] tgt_rdata;

    logic [31:0]  rdata   [3];
    logic [3:0]   t_ren   [3];
    logic [31:0]  t_raddr [3];
    logic [3:0]   t_wen   [3];
    logic [31:0]  t_waddr [3];
    logic [31:0]  t_wdata [3];
    logic [3:0]   t_wstrb [3];
    logic         o_err   [3];
    logic [31:0]  o_eaddr [3];
    logic [15:0]  o_ecnt  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign tgt_rdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            svc_rv_io_demux #(.RD_LAT(gi + 1)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .io_ren    (io_ren),
                .io_raddr  (io_raddr),
                .io_rdata  (rdata[gi]),
                .io_wen    (io_wen),
                .io_waddr  (io_waddr),
                .io_wdata  (io_wdata),
                .io_wstrb  (io_wstrb),
                .tgt_ren   (t_ren[gi]),
                .tgt_raddr (t_raddr[gi]),
                .tgt_rdata (tgt_rdata),
                .tgt_wen   (t_wen[gi]),
                .tgt_waddr (t_waddr[gi]),
                .tgt_wdata (t_wdata[gi]),
                .tgt_wstrb (t_wstrb[gi]),
                .err_clr   (err_clr),
                .err       (o_err[gi]),
                .err_addr  (o_eaddr[gi]),
                .err_cnt   (o_ecnt[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b2b_addr [3] = '{32'h0000_0000, 32'h0000_2004, 32'h0000_3008};
    logic [31:0] b2b_data [3] = '{32'hA5A5_0000, 32'hA5A5_0002, 32'hA5A5_0003};
    logic [31:0] b2b_off  [3] = '{32'h0, 32'h4, 32'h8};

    initial begin
        rst = 1'b1; io_ren = 1'b0; io_wen = 1'b0; err_clr = 1'b0;
        io_raddr = '0; io_waddr = '0; io_wdata = '0; io_wstrb = '0;
        cyc(); cyc();
        // reset state
        chk("rst_rdata_l1", rdata[0], 0);
        chk("rst_rdata_l3", rdata[2], 0);
        chk("rst_err", o_err[0], 0);
        chk("rst_err_cnt", o_ecnt[0], 0);
        chk("rst_err_addr", o_eaddr[0], 0);
        rst = 1'b0;
        cyc();

        // mapped read to target 1
        io_ren = 1'b1; io_raddr = 32'h0000_1008; #1;
        chk("map_tgt_ren", t_ren[0], 4'b0010);
        chk("map_tgt_raddr", t_raddr[0], 32'h8);
        cyc(); io_ren = 1'b0; #1;
        chk("map_rdata_l1", rdata[0], 32'hA5A5_0001);
        chk("map_rdata_l2_early", rdata[1], 0);
        cyc();
        chk("map_rdata_l1_idle", rdata[0], 0);
        chk("map_rdata_l2", rdata[1], 32'hA5A5_0001);
        cyc();
        chk("map_rdata_l3", rdata[2], 32'hA5A5_0001);
        cyc(); cyc();

        // back-to-back reads to targets 0, 2, 3
        for (int s = 0; s < 6; s++) begin
            cyc();
            if (s < 3) begin io_ren = 1'b1; io_raddr = b2b_addr[s]; end
            else       begin io_ren = 1'b0; io_raddr = '0; end
            #1;
            if (s < 3) chk("b2b_raddr", t_raddr[1], b2b_off[s]);
            chk("b2b_rdata_l1", rdata[0], (s >= 1 && s <= 3) ? b2b_data[s-1] : 32'h0);
            chk("b2b_rdata_l2", rdata[1], (s >= 2 && s <= 4) ? b2b_data[s-2] : 32'h0);
        end
        cyc(); cyc();

        // unmapped reads
        io_ren = 1'b1; io_raddr = 32'h0000_8000;
        cyc(); io_ren = 1'b0;
        chk("unm_rdata_l1", rdata[0], 32'hDEAD_BEEF);
        chk("unm_err", o_err[0], 1);
        chk("unm_err_addr", o_eaddr[0], 32'h8000);
        chk("unm_err_cnt", o_ecnt[0], 1);
        cyc();
        chk("unm_rdata_l2", rdata[1], 32'hDEAD_BEEF);
        io_ren = 1'b1; io_raddr = 32'h0000_9000;
        cyc(); io_ren = 1'b0;
        chk("unm2_err_addr", o_eaddr[0], 32'h8000);
        chk("unm2_err_cnt", o_ecnt[0], 2);

        // simultaneous mapped read and write, then zero-strobe write
        io_ren = 1'b1; io_raddr = 32'h0000_1010;
        io_wen = 1'b1; io_waddr = 32'h0000_1010; io_wstrb = 4'b0011; io_wdata = 32'h1234_5678;
        #1;
        chk("rw_tgt_wen", t_wen[0], 4'b0010);
        chk("rw_tgt_ren", t_ren[0], 4'b0010);
        chk("rw_tgt_waddr", t_waddr[0], 32'h10);
        chk("rw_tgt_raddr", t_raddr[0], 32'h10);
        chk("rw_tgt_wdata", t_wdata[0], 32'h1234_5678);
        chk("rw_tgt_wstrb", t_wstrb[0], 4'b0011);
        cyc();
        io_ren = 1'b0; io_waddr = 32'h0000_2000; io_wstrb = 4'b0000; #1;
        chk("wstrb0_tgt_wen", t_wen[0], 4'b0000);
        cyc(); io_wen = 1'b0;
        chk("wstrb0_err_cnt", o_ecnt[0], 2);

        // clear priority over an unmapped write
        err_clr = 1'b1; io_wen = 1'b1; io_waddr = 32'h0000_8000; io_wstrb = 4'hF;
        cyc(); err_clr = 1'b0; io_wen = 1'b0;
        chk("clr_err", o_err[0], 0);
        chk("clr_err_cnt", o_ecnt[0], 0);
        io_wen = 1'b1; io_waddr = 32'h0000_A000; io_wstrb = 4'b0001;
        cyc(); io_wen = 1'b0;
        chk("wunm_err", o_err[0], 1);
        chk("wunm_err_addr", o_eaddr[0], 32'hA000);
        chk("wunm_err_cnt", o_ecnt[0], 1);
        err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        // simultaneous unmapped read and write: read address wins, count +2
        io_ren = 1'b1; io_raddr = 32'h0000_B000;
        io_wen = 1'b1; io_waddr = 32'h0000_C000; io_wstrb = 4'hF;
        cyc();
        chk("rwunm_err_addr", o_eaddr[0], 32'hB000);
        chk("rwunm_err_cnt", o_ecnt[0], 2);
        for (int k = 0; k < 32766; k++) cyc();
        chk("sat_pre_cnt", o_ecnt[0], 16'hFFFE);
        cyc();
        chk("sat_cnt", o_ecnt[0], 16'hFFFF);
        cyc(); io_ren = 1'b0; io_wen = 1'b0; io_wstrb = 4'h0;
        chk("sat_hold_cnt", o_ecnt[0], 16'hFFFF);
        cyc(); cyc(); cyc(); cyc();

        // reset while reads are in flight
        io_ren = 1'b1; io_raddr = 32'h0000_2000;
        cyc(); io_raddr = 32'h0000_3000; #1;
        chk("rstmid_rdata_l1", rdata[0], 32'hA5A5_0002);
        cyc(); rst = 1'b1; io_raddr = 32'h0000_1000; #1;
        chk("rstmid_tgt_ren_l3", t_ren[2], 4'b0000);
        chk("rstmid_tgt_ren_l1", t_ren[0], 4'b0000);
        cyc(); rst = 1'b0; io_ren = 1'b0; #1;
        chk("rstmid_rdata_l3_a", rdata[2], 0);
        chk("rstmid_rdata_l2", rdata[1], 0);
        chk("rstmid_err", o_err[2], 0);
        chk("rstmid_err_cnt", o_ecnt[2], 0);
        cyc();
        chk("rstmid_rdata_l3_b", rdata[2], 0);
        chk("rstmid_rdata_l1", rdata[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
